cgra_config_sequencer: RTL and testbench



---
 rtl/cgra_config_pkg.sv | 24 ++
 rtl/cgra_config_word_shifter.sv | 36 +++
 rtl/cgra_config_sequencer.sv | 132 +++++++++++++
 tb/tb_cgra_config_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_config_pkg.sv
// Shared types and sizing helpers for the CGRA configuration sequencer.
package cgra_config_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT,
        DONE
    } state_t;

    // Number of memory words holding one context.
    function automatic int unsigned words_per_ctx(input int unsigned total_bits,
                                                  input int unsigned word_width);
        return (total_bits + word_width - 1) / word_width;
    endfunction

    // Bits of the final word that reach the chain (its upper bits).
    function automatic int unsigned last_word_bits(input int unsigned total_bits,
                                                   input int unsigned word_width);
        return total_bits - (words_per_ctx(total_bits, word_width) - 1) * word_width;
    endfunction

endpackage

// File: rtl/cgra_config_word_shifter.sv
// MSB-first word serializer with a programmable per-word bit count.
// head_c already reflects a word being loaded this cycle, so load and first shift may coincide.
module cgra_config_word_shifter #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  sync_reset_n,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] load_data,
    input  logic                  shift,
    input  logic [CNT_WIDTH-1:0]  length,
    output logic                  head_c,
    output logic                  exhausted_c
);

    logic [WORD_WIDTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]  count;

    assign head_c      = load ? load_data[WORD_WIDTH-1] : shreg[WORD_WIDTH-1];
    assign exhausted_c = (count == length);

    always_ff @(posedge clock) begin
        if (!sync_reset_n) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= shift ? (load_data << 1) : load_data;
            count <= shift ? CNT_WIDTH'(1) : '0;
        end else if (shift) begin
            shreg <= shreg << 1;
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cgra_config_sequencer.sv
// Streams one stored CGRA context from config memory into the serial configuration chain.
// hold is sampled on the clock edge; a held edge produces a stall cycle on the following cycle.
module cgra_config_sequencer
    import cgra_config_pkg::*;
#(
    parameter int unsigned TOTAL_NUM_BITS = 832,
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned NUM_CONTEXTS   = 4,
    parameter int unsigned ADDR_WIDTH     = 8,
    localparam int unsigned CTX_WIDTH     = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
    input  logic                  clock,
    input  logic                  sync_reset_n,
    input  logic                  start,
    input  logic [CTX_WIDTH-1:0]  context_id,
    input  logic                  hold,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  bitstream,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  cgra_run,
    output logic                  start_err
);

    localparam int unsigned WORDS         = words_per_ctx(TOTAL_NUM_BITS, WORD_WIDTH);
    localparam int unsigned LAST_BITS     = last_word_bits(TOTAL_NUM_BITS, WORD_WIDTH);
    localparam int unsigned CNT_WIDTH     = $clog2(WORD_WIDTH + 1);
    localparam int unsigned WIDX_WIDTH    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CTX_CMP_WIDTH = CTX_WIDTH + 1;

    state_t                state_q;
    state_t                state_n;
    logic [WIDX_WIDTH-1:0] word_idx_q;
    logic                  ctx_ok_c;
    logic                  accept_c;
    logic                  last_word_c;
    logic                  word_done_c;
    logic                  emit_c;
    logic                  bit_n;
    logic                  head_c;
    logic                  exhausted_c;
    logic [CNT_WIDTH-1:0]  length_c;
    logic [ADDR_WIDTH-1:0] base_addr_c;

    assign ctx_ok_c    = {1'b0, context_id} < CTX_CMP_WIDTH'(NUM_CONTEXTS);
    assign accept_c    = (state_q == IDLE) && start && ctx_ok_c;
    assign last_word_c = (word_idx_q == WIDX_WIDTH'(WORDS - 1));
    assign word_done_c = (state_q == SHIFT) && exhausted_c;
    assign length_c    = last_word_c ? CNT_WIDTH'(LAST_BITS) : CNT_WIDTH'(WORD_WIDTH);
    assign base_addr_c = ADDR_WIDTH'(context_id) * ADDR_WIDTH'(WORDS);

    cgra_config_word_shifter #(
        .WORD_WIDTH (WORD_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_shifter (
        .clock        (clock),
        .sync_reset_n (sync_reset_n),
        .load         (state_q == WAIT),
        .load_data    (mem_rdata),
        .shift        (emit_c),
        .length       (length_c),
        .head_c       (head_c),
        .exhausted_c  (exhausted_c)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!sync_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state, plus what the upcoming cycle drives onto the chain.
    always_comb begin
        state_n = state_q;
        emit_c  = 1'b0;
        bit_n   = 1'b0;
        case (state_q)
            IDLE:    if (accept_c) state_n = FETCH;
            FETCH:   state_n = WAIT;
            WAIT:    state_n = SHIFT;
            SHIFT:   if (exhausted_c) state_n = last_word_c ? DONE : FETCH;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        emit_c = (state_n == SHIFT) && !hold;
        if (emit_c) begin
            bit_n = head_c;
        end else if (state_n == SHIFT) begin
            bit_n = bitstream;
        end
    end

    // Registered outputs and address/word tracking.
    always_ff @(posedge clock) begin
        if (!sync_reset_n) begin
            word_idx_q    <= '0;
            mem_addr      <= '0;
            mem_rd_en     <= 1'b0;
            bitstream     <= 1'b0;
            config_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cgra_run      <= 1'b0;
            start_err     <= 1'b0;
        end else begin
            mem_rd_en     <= (state_n == FETCH);
            config_enable <= emit_c;
            bitstream     <= bit_n;
            busy          <= (state_n != IDLE);
            done          <= (state_n == DONE);
            start_err     <= start && !accept_c;
            if (accept_c) begin
                mem_addr   <= base_addr_c;
                word_idx_q <= '0;
                cgra_run   <= 1'b0;
            end else if (word_done_c && !last_word_c) begin
                mem_addr   <= mem_addr + ADDR_WIDTH'(1);
                word_idx_q <= word_idx_q + WIDX_WIDTH'(1);
            end
            if (state_q == DONE) begin
                cgra_run <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Directed bench: full-size sequencer (832 bits, 4 contexts) plus a 40-bit, 3-context instance.
module tb_cgra_config_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic sync_reset_n;

    logic        start_a, hold_a, rd_a, bit_a, en_a, busy_a, done_a, cgra_run_a, err_a;
    logic [1:0]  ctx_a;
    logic [7:0]  addr_a;
    logic [31:0] rdata_a;

    logic        start_b, hold_b, rd_b, bit_b, en_b, busy_b, done_b, cgra_run_b, err_b;
    logic [1:0]  ctx_b;
    logic [7:0]  addr_b;
    logic [31:0] rdata_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    int errors = 0;
    int checks = 0;

    // Per-cycle log for DUT A: {start_err, cgra_run, done, busy, mem_rd_en, config_enable, bitstream}
    logic [6:0] log_a  [0:1023];
    logic [7:0] alog_a [0:1023];
    int done_cyc, done_cnt, en_cnt, rd_cnt, err_cnt, first_en, first_addr, last_addr, chain_bad;

    cgra_config_sequencer dut_a (
        .clock         (clock),
        .sync_reset_n  (sync_reset_n),
        .start         (start_a),
        .context_id    (ctx_a),
        .hold          (hold_a),
        .mem_rd_en     (rd_a),
        .mem_addr      (addr_a),
        .mem_rdata     (rdata_a),
        .bitstream     (bit_a),
        .config_enable (en_a),
        .busy          (busy_a),
        .done          (done_a),
        .cgra_run      (cgra_run_a),
        .start_err     (err_a)
    );

    cgra_config_sequencer #(
        .TOTAL_NUM_BITS (40),
        .WORD_WIDTH     (32),
        .NUM_CONTEXTS   (3),
        .ADDR_WIDTH     (8)
    ) dut_b (
        .clock         (clock),
        .sync_reset_n  (sync_reset_n),
        .start         (start_b),
        .context_id    (ctx_b),
        .hold          (hold_b),
        .mem_rd_en     (rd_b),
        .mem_addr      (addr_b),
        .mem_rdata     (rdata_b),
        .bitstream     (bit_b),
        .config_enable (en_b),
        .busy          (busy_b),
        .done          (done_b),
        .cgra_run      (cgra_run_b),
        .start_err     (err_b)
    );

    // Synchronous config memories: data valid the cycle after the read strobe.
    always @(posedge clock) if (rd_a) rdata_a <= mem_a[addr_a];
    always @(posedge clock) if (rd_b) rdata_b <= mem_b[addr_b];

    // Starts a load on DUT A and records cycles 1..cycles after the accepting edge.
    task automatic do_load_a(input int ctx, input int cycles, input int hold_from, input int hold_to,
                             input int err1, input int err2, input int rst_at);
        logic [31:0] w;
        done_cyc = 0; done_cnt = 0; en_cnt = 0; rd_cnt = 0; err_cnt = 0;
        first_en = 0; first_addr = -1; last_addr = -1; chain_bad = 0;
        @(negedge clock);
        start_a = 1'b1;
        ctx_a   = 2'(ctx);
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clock);
            log_a[k]  = {err_a, cgra_run_a, done_a, busy_a, rd_a, en_a, bit_a};
            alog_a[k] = addr_a;
            if (done_a) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (err_a) err_cnt++;
            if (rd_a) begin
                rd_cnt++;
                if (first_addr < 0) first_addr = int'(addr_a);
                last_addr = int'(addr_a);
            end
            if (en_a) begin
                if (first_en == 0) first_en = k;
                w = 32'h8000_0001 ^ 32'(ctx * 26 + en_cnt / 32);
                if (bit_a !== w[31 - (en_cnt % 32)]) chain_bad++;
                en_cnt++;
            end
            start_a      = (k == err1) || (k == err2);
            ctx_a        = 2'(ctx + 1);
            hold_a       = (k >= hold_from) && (k <= hold_to);
            sync_reset_n = (k != rst_at);
        end
        start_a = 1'b0;
        hold_a  = 1'b0;
        sync_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        sync_reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({err_a, cgra_run_a, done_a, busy_a, rd_a, en_a, bit_a, addr_a} !== 15'd0) begin
            errors++;
            $display("FAIL reset_a: got %b expected all zero",
                     {err_a, cgra_run_a, done_a, busy_a, rd_a, en_a, bit_a, addr_a});
        end
        checks++;
        if ({err_b, cgra_run_b, done_b, busy_b, rd_b, en_b, bit_b, addr_b} !== 15'd0) begin
            errors++;
            $display("FAIL reset_b: got %b expected all zero",
                     {err_b, cgra_run_b, done_b, busy_b, rd_b, en_b, bit_b, addr_b});
        end
        sync_reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_context0();
        do_load_a(0, 890, 0, -1, 0, 0, 0);
        checks++;
        if (log_a[1][3] !== 1'b1) begin errors++; $display("FAIL ctx0_busy_rise: got %b expected 1", log_a[1][3]); end
        checks++;
        if (first_en !== 3) begin errors++; $display("FAIL ctx0_first_enable: got %0d expected 3", first_en); end
        checks++;
        if (en_cnt !== 832) begin errors++; $display("FAIL ctx0_enable_count: got %0d expected 832", en_cnt); end
        checks++;
        if (chain_bad !== 0) begin errors++; $display("FAIL ctx0_chain: got %0d bad bits expected 0", chain_bad); end
        checks++;
        if (done_cyc !== 885) begin errors++; $display("FAIL ctx0_done_cycle: got %0d expected 885", done_cyc); end
        checks++;
        if (rd_cnt !== 26) begin errors++; $display("FAIL ctx0_reads: got %0d expected 26", rd_cnt); end
        checks++;
        if (first_addr !== 0) begin errors++; $display("FAIL ctx0_first_addr: got %0d expected 0", first_addr); end
        checks++;
        if (log_a[886][5:3] !== 3'b100) begin
            errors++; $display("FAIL ctx0_run_after_done: got run/done/busy=%b expected 100", log_a[886][5:3]);
        end
    endtask

    task automatic test_context3();
        do_load_a(3, 890, 0, -1, 0, 0, 0);
        checks++;
        if (log_a[1][5] !== 1'b0) begin errors++; $display("FAIL ctx3_run_cleared: got %b expected 0", log_a[1][5]); end
        checks++;
        if (first_addr !== 78) begin errors++; $display("FAIL ctx3_first_addr: got %0d expected 78", first_addr); end
        checks++;
        if (last_addr !== 103) begin errors++; $display("FAIL ctx3_last_addr: got %0d expected 103", last_addr); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL ctx3_done_width: got %0d expected 1", done_cnt); end
        checks++;
        if (chain_bad !== 0) begin errors++; $display("FAIL ctx3_chain: got %0d bad bits expected 0", chain_bad); end
    endtask

    task automatic test_hold();
        int stall_bad;
        stall_bad = 0;
        // Cycle 101 emits bit 1 of word 2 (32'h8000_0003), a one; cycles 102..106 stall.
        do_load_a(0, 895, 101, 105, 0, 0, 0);
        for (int k = 102; k <= 106; k++) begin
            if (log_a[k][1:0] !== 2'b01) stall_bad++;
        end
        checks++;
        if (log_a[101][1:0] !== 2'b11) begin errors++; $display("FAIL hold_pre_bit: got %b expected 11", log_a[101][1:0]); end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL hold_stall: got %0d bad cycles expected 0", stall_bad); end
        checks++;
        if (log_a[107][1] !== 1'b1) begin errors++; $display("FAIL hold_resume: got %b expected 1", log_a[107][1]); end
        checks++;
        if (en_cnt !== 832) begin errors++; $display("FAIL hold_enable_count: got %0d expected 832", en_cnt); end
        checks++;
        if (done_cyc !== 890) begin errors++; $display("FAIL hold_done_cycle: got %0d expected 890", done_cyc); end
        checks++;
        if (chain_bad !== 0) begin errors++; $display("FAIL hold_chain: got %0d bad bits expected 0", chain_bad); end
    endtask

    task automatic test_start_err();
        do_load_a(1, 890, 0, -1, 10, 885, 0);
        checks++;
        if ({log_a[11][6], log_a[12][6]} !== 2'b10) begin
            errors++; $display("FAIL err_busy_pulse: got %b expected 10", {log_a[11][6], log_a[12][6]});
        end
        checks++;
        if (log_a[886][6] !== 1'b1) begin errors++; $display("FAIL err_in_done: got %b expected 1", log_a[886][6]); end
        checks++;
        if (err_cnt !== 2) begin errors++; $display("FAIL err_count: got %0d expected 2", err_cnt); end
        checks++;
        if (done_cyc !== 885 || chain_bad !== 0) begin
            errors++; $display("FAIL err_load_intact: got done=%0d bad=%0d expected 885 0", done_cyc, chain_bad);
        end
        checks++;
        if ({log_a[890][5], log_a[890][3], log_a[888][3]} !== 3'b100) begin
            errors++; $display("FAIL err_no_restart: got %b expected 100", {log_a[890][5], log_a[890][3], log_a[888][3]});
        end
    endtask

    task automatic test_short_chain();
        logic [39:0] cap;
        int nen, dcyc;
        cap = '0; nen = 0; dcyc = 0;
        @(negedge clock);
        start_b = 1'b1;
        ctx_b   = 2'd0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (en_b) begin
                cap = {cap[38:0], bit_b};
                nen++;
            end
            if (done_b && dcyc == 0) dcyc = k;
            start_b = 1'b0;
        end
        checks++;
        if (nen !== 40) begin errors++; $display("FAIL short_enable_count: got %0d expected 40", nen); end
        checks++;
        if (cap[7:0] !== 8'hAB) begin errors++; $display("FAIL short_last_bits: got %h expected ab", cap[7:0]); end
        checks++;
        if (cap[39:8] !== 32'hC3C3_5A5A) begin errors++; $display("FAIL short_word0: got %h expected c3c35a5a", cap[39:8]); end
        checks++;
        if (dcyc !== 45) begin errors++; $display("FAIL short_done_cycle: got %0d expected 45", dcyc); end
        checks++;
        if (cgra_run_b !== 1'b1) begin errors++; $display("FAIL short_run: got %b expected 1", cgra_run_b); end
    endtask

    task automatic test_invalid_ctx();
        @(negedge clock);
        start_b = 1'b1;
        ctx_b   = 2'd3;
        @(negedge clock);
        start_b = 1'b0;
        ctx_b   = 2'd0;
        checks++;
        if ({err_b, busy_b, cgra_run_b} !== 3'b101) begin
            errors++; $display("FAIL invalid_ctx_pulse: got err/busy/run=%b expected 101", {err_b, busy_b, cgra_run_b});
        end
        @(negedge clock);
        checks++;
        if ({err_b, busy_b, rd_b, cgra_run_b} !== 4'b0001) begin
            errors++; $display("FAIL invalid_ctx_idle: got err/busy/rd/run=%b expected 0001", {err_b, busy_b, rd_b, cgra_run_b});
        end
    endtask

    task automatic test_reset_midload();
        do_load_a(2, 352, 0, -1, 0, 0, 350);
        checks++;
        if (log_a[350][1] !== 1'b1 || alog_a[350] !== 8'd62) begin
            errors++; $display("FAIL midload_pre_reset: got en=%b addr=%0d expected 1 62", log_a[350][1], alog_a[350]);
        end
        checks++;
        if ({log_a[351], alog_a[351]} !== 15'd0) begin
            errors++; $display("FAIL midload_reset_outputs: got %b expected all zero", {log_a[351], alog_a[351]});
        end
        do_load_a(1, 890, 0, -1, 0, 0, 0);
        checks++;
        if (first_addr !== 26 || first_en !== 3) begin
            errors++; $display("FAIL reload_start: got addr=%0d first_en=%0d expected 26 3", first_addr, first_en);
        end
        checks++;
        if (chain_bad !== 0 || en_cnt !== 832 || done_cyc !== 885) begin
            errors++; $display("FAIL reload_chain: got bad=%0d en=%0d done=%0d expected 0 832 885", chain_bad, en_cnt, done_cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h8000_0001 ^ 32'(i);
            mem_b[i] = 32'hFFFF_FFFF;
        end
        mem_b[0] = 32'hC3C3_5A5A;
        mem_b[1] = 32'hAB00_0000;
        rdata_a = '0; rdata_b = '0;
        start_a = 1'b0; hold_a = 1'b0; ctx_a = 2'd0;
        start_b = 1'b0; hold_b = 1'b0; ctx_b = 2'd0;
        sync_reset_n = 1'b0;

        test_reset();
        test_context0();
        test_context3();
        test_hold();
        test_start_err();
        test_short_chain();
        test_invalid_ctx();
        test_reset_midload();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
